// File: rtl/keypad_matrix_scanner.sv
// 7x5 keypad matrix scanner: drives one line low per slot, snapshots the columns
// into a full frame and debounces single-key presses/releases frame by frame.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] L,
    input  logic [4:0] C,
    output logic [7:0] code,
    output logic       valid,
    input  logic       ack,
    output logic       held,
    output logic       multi,
    output logic       overrun,
    input  logic       clr
);
    typedef enum logic [1:0] {SCAN, PRESS_DB, DOWN, RELEASE_DB} state_t;

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB        = 4'(DEBOUNCE);

    logic [4:0]  c_meta_q, c_sync_q;
    logic        run_q;
    logic [15:0] slot_q;
    logic [2:0]  line_q;
    logic [6:0]  l_q;
    logic [34:0] snap_q;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  cand_q, code_q;
    logic        valid_q, held_q, multi_q, over_q;

    logic        sample, frame_end, none, one, many, same, accept;
    logic [34:0] frame_w;
    logic [7:0]  key_w;
    logic [3:0]  cnt_inc;

    assign sample    = run_q && (slot_q == SLOT_LAST);
    assign frame_end = sample && (line_q == 3'd6);
    // Line 6 is still in the synchroniser at frame end, so splice it in directly.
    assign frame_w   = {~c_sync_q, snap_q[29:0]};
    assign none      = (frame_w == 35'd0);
    assign one       = !none && ((frame_w & (frame_w - 35'd1)) == 35'd0);
    assign many      = !none && !one;
    assign same      = one && (key_w == cand_q);
    assign cnt_inc   = cnt_q + 4'd1;

    always_comb begin
        key_w = 8'd0;
        for (int i = 0; i < 7; i++)
            if (frame_w[5*i +: 5] != 5'd0) key_w = {frame_w[5*i +: 5], 3'(i)};
    end

    always_comb begin
        accept = 1'b0;
        if (frame_end && one) begin
            case (state_q)
                SCAN:     accept = (DB == 4'd1);
                PRESS_DB: accept = same && (cnt_inc >= DB);
                default:  accept = 1'b0;
            endcase
        end
    end

    assign L       = l_q;
    assign code    = code_q;
    assign valid   = valid_q;
    assign held    = held_q;
    assign multi   = multi_q;
    assign overrun = over_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_meta_q <= 5'h1F;
            c_sync_q <= 5'h1F;
            run_q    <= 1'b0;
            slot_q   <= 16'd0;
            line_q   <= 3'd0;
            l_q      <= 7'h7F;
            snap_q   <= 35'd0;
        end else begin
            c_meta_q <= C;
            c_sync_q <= c_meta_q;
            if (!run_q) begin
                run_q <= 1'b1;
                l_q   <= 7'h7E;
            end else if (sample) begin
                slot_q <= 16'd0;
                line_q <= (line_q == 3'd6) ? 3'd0 : line_q + 3'd1;
                l_q    <= {l_q[5:0], l_q[6]};
                snap_q[5*line_q +: 5] <= ~c_sync_q;
            end else begin
                slot_q <= slot_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            cnt_q   <= 4'd0;
            cand_q  <= 8'd0;
            code_q  <= 8'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            if (frame_end) begin
                case (state_q)
                    SCAN: if (one) begin
                        cand_q  <= key_w;
                        cnt_q   <= 4'd1;
                        state_q <= accept ? DOWN : PRESS_DB;
                    end
                    PRESS_DB: if (same) begin
                        cnt_q <= cnt_inc;
                        if (accept) state_q <= DOWN;
                    end else begin
                        state_q <= SCAN;
                    end
                    DOWN: if (!same) begin
                        cnt_q <= 4'd1;
                        if (none && DB == 4'd1) begin
                            held_q  <= 1'b0;
                            state_q <= SCAN;
                        end else begin
                            state_q <= RELEASE_DB;
                        end
                    end
                    RELEASE_DB: if (none) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc >= DB) begin
                            held_q  <= 1'b0;
                            state_q <= SCAN;
                        end
                    end else if (same) begin
                        state_q <= DOWN;
                    end else begin
                        cnt_q <= 4'd0;
                    end
                endcase
            end
            if (accept) begin
                code_q  <= key_w;
                valid_q <= 1'b1;
                held_q  <= 1'b1;
            end else if (valid_q && ack) begin
                valid_q <= 1'b0;
            end
            if (frame_end && many) multi_q <= 1'b1;
            else if (clr)          multi_q <= 1'b0;
            // An ack landing on the accept edge consumes the old code, so no overrun.
            if (accept && valid_q && !ack) over_q <= 1'b1;
            else if (clr)                  over_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Frame-level bench for keypad_matrix_scanner: a key matrix model answers the line
// drives, and a per-frame reference of the debounce rules predicts every output.
module tb_keypad_matrix_scanner;
    localparam int S  = 8;
    localparam int DB = 2;
    localparam int FR = 7 * S;
    localparam int ST_SCAN = 0, ST_PRESS = 1, ST_DOWN = 2, ST_REL = 3;

    logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0, clr = 1'b0;
    logic [6:0] L;
    logic [4:0] C;
    logic [7:0] code;
    logic valid, held, multi, overrun;
    logic [34:0] keys = '0;
    int total = 0, bad = 0, cyc = 0;

    int m_st, m_cnt;
    logic [7:0] m_cand, m_code;
    bit m_valid, m_held, m_multi, m_over, post_ack_valid;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(.SCAN_DIV(S), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst_n(rst_n), .L(L), .C(C), .code(code), .valid(valid),
        .ack(ack), .held(held), .multi(multi), .overrun(overrun), .clr(clr));

    always_comb begin
        C = 5'h1F;
        for (int l = 0; l < 7; l++)
            if (!L[l]) C = C & ~keys[5*l +: 5];
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [6:0] e;
        if (!rst_n || cyc == 0) e = 7'h7F;
        else e = ~(7'b1 << (((cyc - 1) / S) % 7));
        total++;
        if (L !== e) begin
            bad++;
            $display("FAIL line_drive cyc=%0d L=%b expected=%b", cyc, L, e);
        end
    end

    function automatic logic [34:0] kbit(input int l, input int c);
        kbit = 35'd1 << (5 * l + c);
    endfunction

    function automatic logic [7:0] key_of(input logic [34:0] f);
        for (int b = 0; b < 35; b++)
            if (f[b]) return {5'(1 << (b % 5)), 3'(b / 5)};
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_st = ST_SCAN; m_cnt = 0; m_cand = 0; m_code = 0;
        m_valid = 0; m_held = 0; m_multi = 0; m_over = 0;
    endtask

    task automatic model_frame(input logic [34:0] f, input bit ack_end, input bit clr_end);
        int n; logic [7:0] k; bit acc;
        n = $countones(f); k = key_of(f); acc = 0;
        if (clr_end) begin m_multi = 0; m_over = 0; end
        if (n > 1) m_multi = 1;
        case (m_st)
            ST_SCAN: if (n == 1) begin
                m_cand = k; m_cnt = 1;
                if (m_cnt >= DB) acc = 1; else m_st = ST_PRESS;
            end
            ST_PRESS: if (n == 1 && k == m_cand) begin
                m_cnt++;
                if (m_cnt >= DB) acc = 1;
            end else m_st = ST_SCAN;
            ST_DOWN: if (!(n == 1 && k == m_cand)) begin
                m_cnt = 1;
                if (n == 0 && DB == 1) begin m_held = 0; m_st = ST_SCAN; end
                else m_st = ST_REL;
            end
            default: if (n == 0) begin
                m_cnt++;
                if (m_cnt >= DB) begin m_held = 0; m_st = ST_SCAN; end
            end else if (n == 1 && k == m_cand) m_st = ST_DOWN;
            else m_cnt = 0;
        endcase
        if (acc) begin
            m_st = ST_DOWN;
            if (m_valid && !ack_end) m_over = 1;
            m_code = m_cand; m_valid = 1; m_held = 1;
        end else if (ack_end && m_valid) m_valid = 0;
    endtask

    // One full frame with keys held steady; optional ack/clr pulse at a cycle index.
    task automatic run_frame(input logic [34:0] k, input int ack_at, input int clr_at);
        keys = k;
        for (int c = 0; c < FR; c++) begin
            ack = (c == ack_at);
            clr = (c == clr_at);
            @(posedge clk); #1;
            if (c != FR - 1) begin
                if (c == ack_at) begin m_valid = 0; post_ack_valid = valid; end
                if (c == clr_at) begin m_multi = 0; m_over = 0; end
            end
        end
        ack = 0; clr = 0;
        model_frame(k, ack_at == FR - 1, clr_at == FR - 1);
    endtask

    task automatic test_reset();
        rst_n = 0; keys = 0;
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (code !== 8'h00) begin bad++; $display("FAIL reset_code got=%h want=00", code); end
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        if (held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", held); end
        if (multi !== 1'b0) begin bad++; $display("FAIL reset_multi got=%b want=0", multi); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        rst_n = 1;
        @(posedge clk); #1;
        model_reset();
        total++;
        if (L !== 7'h7E) begin bad++; $display("FAIL first_line got=%b want=1111110", L); end
    endtask

    task automatic test_basic_press();
        run_frame(kbit(3, 2), -1, -1);
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", valid); end
        run_frame(kbit(3, 2), -1, -1);
        total += 3;
        if (valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", valid); end
        if (code !== 8'h23) begin bad++; $display("FAIL basic_code got=%h want=23", code); end
        if (held !== 1'b1) begin bad++; $display("FAIL basic_held got=%b want=1", held); end
        run_frame(0, 3, -1);
        total += 2;
        if (post_ack_valid !== 1'b0) begin bad++; $display("FAIL basic_ack got=%b want=0", post_ack_valid); end
        if (held !== 1'b1) begin bad++; $display("FAIL basic_held_rel1 got=%b want=1", held); end
        run_frame(0, -1, -1);
        total += 2;
        if (held !== 1'b0) begin bad++; $display("FAIL basic_released got=%b want=0", held); end
        if (code !== 8'h23) begin bad++; $display("FAIL basic_code_hold got=%h want=23", code); end
    endtask

    task automatic test_short_press();
        keys = kbit(3, 2);
        for (int c = 0; c < FR; c++) begin
            if (c == 40) keys = 0;
            @(posedge clk); #1;
        end
        model_frame(kbit(3, 2), 0, 0);
        run_frame(0, -1, -1);
        run_frame(kbit(3, 2), -1, -1);
        total += 2;
        if (valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%b want=0", valid); end
        if (held !== 1'b0) begin bad++; $display("FAIL short_held got=%b want=0", held); end
        run_frame(0, -1, -1);
    endtask

    task automatic test_multi();
        run_frame(kbit(0, 0) | kbit(6, 4), -1, -1);
        total += 2;
        if (multi !== 1'b1) begin bad++; $display("FAIL multi_set got=%b want=1", multi); end
        if (valid !== 1'b0) begin bad++; $display("FAIL multi_valid got=%b want=0", valid); end
        run_frame(0, -1, -1);
        total++;
        if (multi !== 1'b1) begin bad++; $display("FAIL multi_sticky got=%b want=1", multi); end
        run_frame(0, -1, 10);
        total++;
        if (multi !== 1'b0) begin bad++; $display("FAIL multi_clr got=%b want=0", multi); end
    endtask

    task automatic test_overrun();
        repeat (2) run_frame(kbit(1, 0), -1, -1);
        repeat (2) run_frame(0, -1, -1);
        repeat (2) run_frame(kbit(5, 3), -1, -1);
        total += 3;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
        if (code !== 8'h45) begin bad++; $display("FAIL overrun_code got=%h want=45", code); end
        if (valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%b want=1", valid); end
        run_frame(kbit(5, 3), 5, -1);
        total += 2;
        if (post_ack_valid !== 1'b0) begin bad++; $display("FAIL overrun_ack got=%b want=0", post_ack_valid); end
        if (held !== 1'b1) begin bad++; $display("FAIL overrun_held got=%b want=1", held); end
        run_frame(0, -1, 2);
        run_frame(0, -1, -1);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clr got=%b want=0", overrun); end
    endtask

    task automatic test_ack_same_cycle();
        repeat (2) run_frame(kbit(2, 4), -1, -1);
        repeat (2) run_frame(0, -1, -1);
        run_frame(kbit(4, 1), -1, -1);
        run_frame(kbit(4, 1), FR - 1, -1);
        total += 3;
        if (valid !== 1'b1) begin bad++; $display("FAIL ackacc_valid got=%b want=1", valid); end
        if (code !== 8'h14) begin bad++; $display("FAIL ackacc_code got=%h want=14", code); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL ackacc_overrun got=%b want=0", overrun); end
        run_frame(0, 1, -1);
        run_frame(0, -1, -1);
    endtask

    task automatic test_bounce();
        logic [34:0] seq [4];
        bit want [4];
        seq = '{0, kbit(2, 1), 0, 0};
        want = '{1, 1, 1, 0};
        repeat (2) run_frame(kbit(2, 1), -1, -1);
        for (int i = 0; i < 4; i++) begin
            run_frame(seq[i], -1, -1);
            total++;
            if (held !== want[i]) begin bad++; $display("FAIL bounce_held frame=%0d got=%b want=%b", i, held, want[i]); end
        end
    endtask

    task automatic test_reset_mid_press();
        run_frame(kbit(1, 1) | kbit(5, 2), -1, -1);
        run_frame(kbit(4, 4), -1, -1);
        keys = kbit(4, 4);
        repeat (20) @(posedge clk);
        #1 rst_n = 0;
        #1;
        total += 6;
        if (L !== 7'h7F) begin bad++; $display("FAIL rstmid_L got=%b want=1111111", L); end
        if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", valid); end
        if (multi !== 1'b0) begin bad++; $display("FAIL rstmid_multi got=%b want=0", multi); end
        if (code !== 8'h00) begin bad++; $display("FAIL rstmid_code got=%h want=00", code); end
        if (held !== 1'b0) begin bad++; $display("FAIL rstmid_held got=%b want=0", held); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun got=%b want=0", overrun); end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        model_reset();
        run_frame(kbit(4, 4), -1, -1);
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale got=%b want=0", valid); end
        run_frame(kbit(4, 4), -1, -1);
        total += 2;
        if (valid !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", valid); end
        if (code !== 8'h84) begin bad++; $display("FAIL rstmid_code2 got=%h want=84", code); end
        run_frame(0, 4, -1);
        run_frame(0, -1, -1);
    endtask

    task automatic test_random();
        logic [34:0] pool [3];
        logic [34:0] cur;
        int ack_at, clr_at;
        pool = '{kbit(0, 1), kbit(3, 4), kbit(6, 0)};
        cur = 0;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(9) >= 6) begin
                case ($urandom_range(4))
                    0, 1: cur = 0;
                    2, 3: cur = pool[$urandom_range(2)];
                    default: cur = pool[$urandom_range(2)] | pool[$urandom_range(2)];
                endcase
            end
            ack_at = ($urandom_range(3) == 0) ? int'($urandom_range(FR - 1)) : -1;
            clr_at = ($urandom_range(9) == 0) ? int'($urandom_range(FR - 1)) : -1;
            run_frame(cur, ack_at, clr_at);
            total += 5;
            if (valid !== m_valid) begin bad++; $display("FAIL rnd_valid frame=%0d got=%b want=%b", f, valid, m_valid); end
            if (held !== m_held) begin bad++; $display("FAIL rnd_held frame=%0d got=%b want=%b", f, held, m_held); end
            if (multi !== m_multi) begin bad++; $display("FAIL rnd_multi frame=%0d got=%b want=%b", f, multi, m_multi); end
            if (overrun !== m_over) begin bad++; $display("FAIL rnd_overrun frame=%0d got=%b want=%b", f, overrun, m_over); end
            if (code !== m_code) begin bad++; $display("FAIL rnd_code frame=%0d got=%h want=%h", f, code, m_code); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_press();
        test_short_press();
        test_multi();
        test_overrun();
        test_ack_same_cycle();
        test_bounce();
        test_reset_mid_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
